level_to_pulse_array: RTL and testbench

//  N-channel level-to-pulse converter; next generation of the single-channel Mealy LTP FSM.
//  - Per channel: synchronise an async level, detect edges selected per channel at run time,

---
 rtl/ltp_pkg.sv | 17 +
 rtl/ltp_channel.sv | 109 ++++++++++
 rtl/level_to_pulse_array.sv | 43 ++++
 tb/tb_level_to_pulse_array.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ltp_pkg.sv
// Shared definitions for the level-to-pulse array: per-channel edge-select
// codes and the encoding of the per-channel pulse FSM.
package ltp_pkg;

   // Edge-select codes, one 2-bit field per channel
   localparam logic [1:0] LTP_OFF  = 2'b00;
   localparam logic [1:0] LTP_RISE = 2'b01;
   localparam logic [1:0] LTP_FALL = 2'b10;
   localparam logic [1:0] LTP_BOTH = 2'b11;

   // Per-channel FSM states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_PULSE = 1'b1
   } ltp_state_e;

endpackage

// File: rtl/ltp_channel.sv
// One channel of the level-to-pulse array: synchronises an async level,
// detects the edges selected by mode, and emits a registered pulse of
// PULSE_W cycles. Edges arriving while a pulse is running either reload
// the width (RETRIGGER=1) or are dropped and flagged in a sticky overrun.
module ltp_channel
   import ltp_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_W     = 1,
   parameter bit RETRIGGER   = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       level,
   input  logic [1:0] mode,
   input  logic       ovr_clr,
   output logic       pulse,
   output logic       overrun
);

   localparam int CW = $clog2(PULSE_W + 1);
   localparam logic [CW-1:0] RELOAD = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   prev_p1;
   logic                   ls_p0;
   logic                   rise;
   logic                   fall;
   logic                   qual;
   ltp_state_e             state;
   logic [CW-1:0]          cnt;

   assign ls_p0 = sync_chain[SYNC_STAGES-1];
   assign rise  = ls_p0 & ~prev_p1;
   assign fall  = ~ls_p0 & prev_p1;

   // Synchroniser chain followed by the one-cycle-delayed copy used for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_chain <= '0;
         prev_p1    <= 1'b0;
      end else begin
         sync_chain[0] <= level;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_chain[s] <= sync_chain[s-1];
         end
         prev_p1 <= ls_p0;
      end
   end

   // Qualify the detected edge against the edge-select of this cycle
   always_comb begin
      qual = 1'b0;
      unique case (mode)
         LTP_OFF:  qual = 1'b0;
         LTP_RISE: qual = rise;
         LTP_FALL: qual = fall;
         LTP_BOTH: qual = rise | fall;
         default:  qual = 1'b0;
      endcase
   end

   // Pulse FSM with width counter and sticky overrun; an edge during the
   // pulse never extends it unless retriggering is enabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pulse   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (ovr_clr) begin
            overrun <= 1'b0;
         end
         unique case (state)
            ST_IDLE: begin
               if (qual) begin
                  state <= ST_PULSE;
                  cnt   <= RELOAD;
                  pulse <= 1'b1;
               end
            end
            ST_PULSE: begin
               if (qual && RETRIGGER) begin
                  cnt <= RELOAD;
               end else begin
                  // A dropped edge flags overrun (set beats clear) while
                  // the running pulse keeps counting down untouched
                  if (qual) begin
                     overrun <= 1'b1;
                  end
                  if (cnt == '0) begin
                     state <= ST_IDLE;
                     pulse <= 1'b0;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               pulse <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/level_to_pulse_array.sv
// N-channel level-to-pulse converter: independent channels turning async
// button/status levels into fixed-width event pulses, plus an OR of all
// pulses for a single interrupt line.
module level_to_pulse_array
   import ltp_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_W     = 1,
   parameter bit RETRIGGER   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   level,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   ovr_clr,
   output logic [N_CH-1:0]   pulse,
   output logic              any_pulse,
   output logic [N_CH-1:0]   overrun
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ltp_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .PULSE_W     (PULSE_W),
         .RETRIGGER   (RETRIGGER)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .level   (level[i]),
         .mode    (mode[2*i+1:2*i]),
         .ovr_clr (ovr_clr[i]),
         .pulse   (pulse[i]),
         .overrun (overrun[i])
      );
   end

   // Registered pulses are combined without extra delay; zero during reset
   always_comb begin
      any_pulse = |pulse;
   end

endmodule

// File: tb/tb_level_to_pulse_array.sv
// Directed bench for level_to_pulse_array with N_CH=4, SYNC_STAGES=2,
// PULSE_W=3. A non-retriggering and a retriggering instance share inputs.
module tb_level_to_pulse_array;

   logic       clk;
   logic       reset;
   logic [3:0] level;
   logic [7:0] mode;
   logic [3:0] ovr_clr;
   logic [3:0] pulse,    overrun;
   logic [3:0] pulse_rt, overrun_rt;
   logic       any_pulse, any_pulse_rt;

   int n_tests = 0;
   int n_fail  = 0;

   level_to_pulse_array #(.N_CH(4), .SYNC_STAGES(2), .PULSE_W(3), .RETRIGGER(1'b0)) dut (
      .clk(clk), .reset(reset), .level(level), .mode(mode), .ovr_clr(ovr_clr),
      .pulse(pulse), .any_pulse(any_pulse), .overrun(overrun));

   level_to_pulse_array #(.N_CH(4), .SYNC_STAGES(2), .PULSE_W(3), .RETRIGGER(1'b1)) dut_rt (
      .clk(clk), .reset(reset), .level(level), .mode(mode), .ovr_clr(ovr_clr),
      .pulse(pulse_rt), .any_pulse(any_pulse_rt), .overrun(overrun_rt));

   initial clk = 1'b0;
   always #20 clk = ~clk;

   typedef struct {
      logic [3:0] lvl;
      logic [7:0] md;
      logic [3:0] clr;
      logic [3:0] p;
      logic [3:0] o;
      logic [3:0] prt;
   } vec_t;

   vec_t vt [0:38];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] ep, input logic [3:0] eo,
                          input logic [3:0] eprt);
      chk({tag, " pulse"},      {4'b0, pulse},        {4'b0, ep});
      chk({tag, " overrun"},    {4'b0, overrun},      {4'b0, eo});
      chk({tag, " any_pulse"},  {7'b0, any_pulse},    {7'b0, |ep});
      chk({tag, " rt pulse"},   {4'b0, pulse_rt},     {4'b0, eprt});
      chk({tag, " rt overrun"}, {4'b0, overrun_rt},   8'h00);
      chk({tag, " rt any"},     {7'b0, any_pulse_rt}, {7'b0, |eprt});
   endtask

   initial begin
      // ch0: rise pulse, no pulse on fall
      vt[0]  = '{4'b0011, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[1]  = '{4'b0011, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[2]  = '{4'b0011, 8'h55, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      vt[3]  = '{4'b0011, 8'h55, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      vt[4]  = '{4'b0011, 8'h55, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      vt[5]  = '{4'b0011, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[6]  = '{4'b0010, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[7]  = '{4'b0010, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[8]  = '{4'b0010, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[9]  = '{4'b0010, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      // ch2 both edges, second edge inside the pulse
      vt[10] = '{4'b0110, 8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[11] = '{4'b0010, 8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[12] = '{4'b0010, 8'h75, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
      vt[13] = '{4'b0010, 8'h75, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
      vt[14] = '{4'b0010, 8'h75, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
      vt[15] = '{4'b0010, 8'h75, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
      vt[16] = '{4'b0010, 8'h75, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      // ch2 overrun clear colliding with a new dropped edge, then clear alone
      vt[17] = '{4'b0110, 8'h75, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      vt[18] = '{4'b0010, 8'h75, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      vt[19] = '{4'b0010, 8'h75, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
      vt[20] = '{4'b0010, 8'h75, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
      vt[21] = '{4'b0010, 8'h75, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
      vt[22] = '{4'b0010, 8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
      vt[23] = '{4'b0010, 8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      // ch3 mode switched to off mid-pulse, later edges ignored
      vt[24] = '{4'b1010, 8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[25] = '{4'b1010, 8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[26] = '{4'b1010, 8'h75, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
      vt[27] = '{4'b1010, 8'h35, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
      vt[28] = '{4'b1010, 8'h35, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
      vt[29] = '{4'b1010, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[30] = '{4'b0010, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[31] = '{4'b0010, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[32] = '{4'b0010, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[33] = '{4'b1010, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[34] = '{4'b1010, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[35] = '{4'b1010, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      // ch1 falls with rise-only mode: nothing
      vt[36] = '{4'b1000, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[37] = '{4'b1000, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vt[38] = '{4'b1000, 8'h35, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

      // Reset with ch1 level already high
      reset   = 1'b1;
      level   = 4'b0010;
      mode    = 8'h55;
      ovr_clr = 4'b0000;
      #20 reset = 1'b0;
      #5  chk_all("in reset", 4'b0000, 4'b0000, 4'b0000);
      #5  reset = 1'b1;
      #10 chk_all("after release", 4'b0000, 4'b0000, 4'b0000);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk_all($sformatf("rel latency %0d", k), 4'b0000, 4'b0000, 4'b0000);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk_all($sformatf("rel pulse %0d", k), 4'b0010, 4'b0000, 4'b0010);
      end
      @(posedge clk); #1;
      chk_all("rel pulse end", 4'b0000, 4'b0000, 4'b0000);

      // Table-driven vectors: inputs applied after an edge, outputs checked after the next
      for (int v = 0; v <= 38; v++) begin
         level   = vt[v].lvl;
         mode    = vt[v].md;
         ovr_clr = vt[v].clr;
         @(posedge clk); #1;
         chk_all($sformatf("vec %0d", v), vt[v].p, vt[v].o, vt[v].prt);
      end
      ovr_clr = 4'b0000;

      // Async reset in the middle of pulses on ch0 and ch1
      level = 4'b1011;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk_all($sformatf("mid latency %0d", k), 4'b0000, 4'b0000, 4'b0000);
      end
      @(posedge clk); #1;
      chk_all("mid pulse", 4'b0011, 4'b0000, 4'b0011);
      #10 reset = 1'b0;
      #1  chk_all("mid reset drop", 4'b0000, 4'b0000, 4'b0000);
      level = 4'b0000;
      #20 reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk_all($sformatf("post reset %0d", k), 4'b0000, 4'b0000, 4'b0000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
